// File: rtl/bus_arbiter_if.sv
// Bus request/grant bundle shared by the requesters and the round-robin arbiter.
// The arbiter takes the slave side; the requesters drive req from the master side.
interface bus_arbiter_if #(
    parameter int COUNT = 8
);
    logic [COUNT-1:0]         req;
    logic [COUNT-1:0]         grant;
    logic                     grant_valid;
    logic [$clog2(COUNT)-1:0] grant_index;
    logic                     preempt;

    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  grant_index,
        input  preempt
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output grant_index,
        output preempt
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a hold limit that preempts a long owner
// and an optional one-cycle turnaround between owners.
module bus_arbiter #(
    parameter int COUNT      = 8,
    parameter int MAX_HOLD   = 16,
    parameter int TURNAROUND = 1
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);
    localparam int IW = $clog2(COUNT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [IW:0] COUNT_W    = (IW+1)'(COUNT);
    localparam logic [7:0]  MAX_HOLD_W = 8'(MAX_HOLD);

    logic [COUNT-1:0] req;
    logic [1:0]       state_reg, state_next;
    logic [COUNT-1:0] grant_reg, grant_next;
    logic [IW-1:0]    index_reg, index_next;
    logic [IW-1:0]    ptr_reg, ptr_next;
    logic [7:0]       hold_reg, hold_next;
    logic             preempt_reg, preempt_next;

    logic             arb_found;
    logic [IW-1:0]    arb_index;
    logic [IW:0]      arb_sum;
    logic [IW-1:0]    arb_cand;
    logic [COUNT-1:0] arb_onehot;

    logic             owner_req;
    logic             other_req;
    logic [7:0]       hold_inc;
    logic             hold_limit;
    logic             do_arb;

    assign req = bus.req;

    // Search starts one past the last owner and wraps, so the last owner has lowest priority.
    always_comb begin
        arb_found = 1'b0;
        arb_index = '0;
        arb_sum   = '0;
        arb_cand  = '0;
        for (int k = 1; k <= COUNT; k++) begin
            arb_sum = {1'b0, ptr_reg} + (IW+1)'(k);
            if (arb_sum >= COUNT_W) begin
                arb_sum = arb_sum - COUNT_W;
            end
            arb_cand = arb_sum[IW-1:0];
            if (!arb_found && req[arb_cand]) begin
                arb_found = 1'b1;
                arb_index = arb_cand;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < COUNT; gi++) begin : g_onehot
            assign arb_onehot[gi] = arb_found && (arb_index == IW'(gi));
        end
    endgenerate

    assign owner_req = |(req & grant_reg);
    assign other_req = |(req & ~grant_reg);

    // hold_inc counts owned cycles including the current one, so the owner
    // keeps the bus for exactly MAX_HOLD cycles when someone else is waiting.
    assign hold_inc   = (hold_reg == MAX_HOLD_W) ? hold_reg : hold_reg + 8'd1;
    assign hold_limit = (hold_inc == MAX_HOLD_W);

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        index_next   = index_reg;
        ptr_next     = ptr_reg;
        hold_next    = hold_reg;
        preempt_next = 1'b0;
        do_arb       = 1'b0;
        case (state_reg)
            ST_IDLE, ST_GAP: begin
                do_arb = 1'b1;
            end
            ST_OWN: begin
                if (!owner_req || (hold_limit && other_req)) begin
                    preempt_next = owner_req;
                    hold_next    = '0;
                    if (TURNAROUND != 0) begin
                        state_next = ST_GAP;
                        grant_next = '0;
                        index_next = '0;
                    end else begin
                        do_arb = 1'b1;
                    end
                end else begin
                    hold_next = hold_inc;
                end
            end
            default: begin
                do_arb = 1'b1;
            end
        endcase

        if (do_arb) begin
            if (arb_found) begin
                state_next = ST_OWN;
                grant_next = arb_onehot;
                index_next = arb_index;
                ptr_next   = arb_index;
                hold_next  = '0;
            end else begin
                state_next = ST_IDLE;
                grant_next = '0;
                index_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= '0;
            index_reg   <= '0;
            ptr_reg     <= IW'(COUNT - 1);
            hold_reg    <= '0;
            preempt_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            index_reg   <= index_next;
            ptr_reg     <= ptr_next;
            hold_reg    <= hold_next;
            preempt_reg <= preempt_next;
        end
    end

    assign bus.grant       = grant_reg;
    assign bus.grant_valid = |grant_reg;
    assign bus.grant_index = index_reg;
    assign bus.preempt     = preempt_reg;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: one instance with turnaround, one without, both
// four requesters with a hold limit of four, checked against a scoreboard.
module tb_bus_arbiter;
    logic clk;
    logic reset;

    typedef struct packed {
        logic [3:0] g1;
        logic       p1;
        logic [3:0] g0;
        logic       p0;
    } exp_t;

    exp_t exp_q[$];
    int   checks_count = 0;
    int   errors_count = 0;
    int   step_count   = 0;

    bus_arbiter_if #(.COUNT(4)) bus1 ();
    bus_arbiter_if #(.COUNT(4)) bus0 ();

    bus_arbiter #(.COUNT(4), .MAX_HOLD(4), .TURNAROUND(1)) dut_gap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    bus_arbiter #(.COUNT(4), .MAX_HOLD(4), .TURNAROUND(0)) dut_nogap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_count++;
        if (obs !== exp) begin
            errors_count++;
            $display("FAIL %s step %0d observed %0h expected %0h", tag, step_count, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot_to_index(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    task automatic step(input logic rst, input logic [3:0] r1, input logic [3:0] g1, input logic p1,
                        input logic [3:0] r0, input logic [3:0] g0, input logic p0);
        exp_t e;
        reset    = rst;
        bus1.req = r1;
        bus0.req = r0;
        exp_q.push_back({g1, p1, g0, p0});
        @(posedge clk);
        #1;
        step_count++;
        e = exp_q.pop_front();
        $display("step %0d reset=%b req1=%b grant1=%b pre1=%b req0=%b grant0=%b pre0=%b",
                 step_count, rst, r1, bus1.grant, bus1.preempt, r0, bus0.grant, bus0.preempt);
        check_value("grant1",       32'(bus1.grant),       32'(e.g1));
        check_value("grant_valid1", 32'(bus1.grant_valid), 32'(|e.g1));
        check_value("grant_index1", 32'(bus1.grant_index), 32'(onehot_to_index(e.g1)));
        check_value("preempt1",     32'(bus1.preempt),     32'(e.p1));
        check_value("onehot1",      32'($countones(bus1.grant) <= 1), 32'(1));
        check_value("grant0",       32'(bus0.grant),       32'(e.g0));
        check_value("grant_valid0", 32'(bus0.grant_valid), 32'(|e.g0));
        check_value("grant_index0", 32'(bus0.grant_index), 32'(onehot_to_index(e.g0)));
        check_value("preempt0",     32'(bus0.preempt),     32'(e.p0));
        check_value("onehot0",      32'($countones(bus0.grant) <= 1), 32'(1));
    endtask

    // Drive the turnaround instance while the other stays idle.
    task automatic step1(input logic rst, input logic [3:0] r, input logic [3:0] g, input logic p, input int n);
        for (int i = 0; i < n; i++) step(rst, r, g, p, 4'b0000, 4'b0000, 1'b0);
    endtask

    // Drive the no-turnaround instance while the other stays idle.
    task automatic step0(input logic rst, input logic [3:0] r, input logic [3:0] g, input logic p, input int n);
        for (int i = 0; i < n; i++) step(rst, 4'b0000, 4'b0000, 1'b0, r, g, p);
    endtask

    initial begin
        reset    = 1'b1;
        bus1.req = 4'b0000;
        bus0.req = 4'b0000;

        // Reset with all requests high: requests ignored, then idle bus.
        step(1'b1, 4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b0);
        step1(1'b0, 4'b0000, 4'b0000, 1'b0, 5);

        // 1010 from idle: requester 1 first, gap on release, then requester 3.
        step1(1'b0, 4'b1010, 4'b0010, 1'b0, 2);
        step1(1'b0, 4'b1000, 4'b0000, 1'b0, 1);
        step1(1'b0, 4'b1000, 4'b1000, 1'b0, 1);
        step1(1'b0, 4'b0000, 4'b0000, 1'b0, 2);

        // 0011 held: four-cycle slots alternating, each ended by preempt and a gap.
        step1(1'b0, 4'b0011, 4'b0001, 1'b0, 4);
        step1(1'b0, 4'b0011, 4'b0000, 1'b1, 1);
        step1(1'b0, 4'b0011, 4'b0010, 1'b0, 4);
        step1(1'b0, 4'b0011, 4'b0000, 1'b1, 1);
        step1(1'b0, 4'b0011, 4'b0001, 1'b0, 4);
        step1(1'b0, 4'b0011, 4'b0000, 1'b1, 1);
        step1(1'b0, 4'b0000, 4'b0000, 1'b0, 1);

        // Lone requester keeps the bus past the hold limit.
        step1(1'b0, 4'b0100, 4'b0100, 1'b0, 20);

        // Reset mid-ownership, then requester 0 wins first with a fresh hold count.
        step1(1'b1, 4'b1111, 4'b0000, 1'b0, 1);
        step1(1'b0, 4'b1111, 4'b0001, 1'b0, 4);
        step1(1'b0, 4'b1111, 4'b0000, 1'b1, 1);
        step1(1'b0, 4'b1111, 4'b0010, 1'b0, 1);
        step1(1'b0, 4'b0000, 4'b0000, 1'b0, 2);

        // No turnaround: direct one-hot handoff on release and on preempt.
        step0(1'b0, 4'b1001, 4'b0001, 1'b0, 2);
        step0(1'b0, 4'b1000, 4'b1000, 1'b0, 3);
        step0(1'b0, 4'b1001, 4'b1000, 1'b0, 1);
        step0(1'b0, 4'b1001, 4'b0001, 1'b1, 1);
        step0(1'b0, 4'b0000, 4'b0000, 1'b0, 2);

        check_value("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks_count, errors_count);
        $finish;
    end
endmodule
